noc_router_xy: RTL and testbench
================================

# noc_router_xy

Parametrised 5-port mesh router: every input has its own flit FIFO, head flits are routed by dimension-ordered XY routing, and packets are forwarded wormhole-style through registered outputs. Each output has a round-robin arbiter. All ports use req/ack flow control. The block is the per-tile switch instantiated once per mesh node.

## Interface
- FLIT_W, 34: flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type.
- DEPTH, 4: per-input FIFO depth, power of two, ≥2.
- CW, 4: coordinate width.
- X_ID, 0: this router's X coordinate.
- Y_ID, 0: this router's Y coordinate.
- Port index: 0 = local, 1 = north (y+1), 2 = east (x+1), 3 = south (y-1), 4 = west (x-1). Lane p of each vector is port p; flits occupy [p*FLIT_W +: FLIT_W].
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_flit  in  5*FLIT_W  incoming flits.
- in_req  in  5  incoming flit valid.
- out_ack  out  5  input-side ready: FIFO p not full.
- out_flit  out  5*FLIT_W  outgoing flits, registered.
- out_req  out  5  outgoing flit valid.
- in_ack  in  5  downstream ready.

## Operation
- Transfer rule: a flit moves across a link on a rising edge where req and ack are both 1. A sender holds flit and req stable until that edge.
- Flit type: 2'b10 = head, 2'b00 = body, 2'b01 = tail, 2'b11 = single (head and tail). Head/single flits carry dst_x = flit[2*CW-1:CW] and dst_y = flit[CW-1:0].
- Input FIFO p:
  - Writes when in_req[p] && out_ack[p].
  - out_ack[p] = !full, purely from registered count (no same-cycle pass-through).
  - Simultaneous read and write when full is not allowed, because ack is already 0.
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- XY route for a head/single flit at a FIFO head, evaluated in this order:
  - dst_x > X_ID → east.
  - dst_x < X_ID → west.
  - dst_y > Y_ID → north.
  - dst_y < Y_ID → south.
  - Otherwise → local.
  - Comparisons are unsigned.
- Per-input state: IDLE or ROUTED(out). A head makes the input request its route. Once granted, the input is ROUTED and its body/tail flits go to the same output. Forwarding the tail or single flit returns the input to IDLE.
- Per-output lock:
  - Unlocked: a round-robin arbiter picks among IDLE inputs whose FIFO head is a head/single flit routed here.
  - Priority starts at last_grant+1 mod 5. last_grant updates only on a grant.
  - Granting a head (not single) locks the output to that input until its tail is forwarded. Locked outputs accept only the owner's flits.
- Output register p loads a flit when the selected input's FIFO is non-empty and (!out_req[p] || in_ack[p]). The FIFO pops in the same cycle. Throughput is 1 flit/cycle/output.
- A flit whose type does not match input state (body/tail while IDLE) is dropped: popped without forwarding. Not expected in legal traffic.
- Reset, at any time including mid-packet:
  - FIFOs empty; all inputs IDLE; all outputs unlocked; last_grant = 4 (so port 0 wins first).
  - out_req = 0, out_flit = 0, out_ack = all 1 once reset deasserts.
  - Partial packets are lost.

## Timing
- Minimum latency: flit accepted at edge t, out_req high after edge t+1 (2 edges input to output valid).
- With in_ack held at 1, a packet streams with no bubbles after its head.
- Arbitration and route are combinational from FIFO head and registered state. No combinational path from in_req to out_req, or from in_ack to out_ack.
- Backpressure: in_ack[p] = 0 holds out_flit[p] and out_req[p]. The owner FIFO fills; out_ack drops on the edge count reaches DEPTH.
- Two outputs may load from two different inputs in the same cycle. One input feeds at most one output per cycle.

## Test plan
- Local delivery: X_ID=Y_ID=1; single flit on port 0 with dst (1,1) → out_req[0] high 2 edges later, flit unchanged, nothing on other ports.
- XY route: X_ID=Y_ID=1; heads to (3,0), (0,2), (1,3), (1,0) → exits east, west, north, south respectively; X is resolved before Y.
- Round-robin: inputs 1, 2, 3 each send a single flit to local every cycle → out_flit[0] sources cycle 1, 2, 3, 1, … after reset (last_grant=4).
- Wormhole: input 1 sends head, 3 bodies, tail to east while input 3 sends a single to east → all 5 flits from input 1 are contiguous, then input 3's flit.
- Backpressure: in_ack[2]=0 while a 6-flit packet enters port 0 toward east, DEPTH=4 → out_ack[0] low after 1 flit in the output register + 4 in the FIFO; release → all 6 flits emitted in order, no loss or duplication.
- Reset mid-packet: assert rst after head + 1 body → outputs 0 immediately; after release, a new single flit routes correctly and the old lock is gone.

Source files
------------

// File: rtl/noc_router_xy.sv
// rtl/noc_router_xy.sv - 5-port XY-routed wormhole mesh router with per-input FIFOs
//
// Ports (lane p of each vector is port p: 0 local, 1 north, 2 east, 3 south, 4 west)
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_flit   in   5*FLIT_W incoming flits, lane p at [p*FLIT_W +: FLIT_W]
//   in_req    in   5 incoming flit valid
//   out_ack   out  5 input-side ready (input FIFO p not full)
//   out_flit  out  5*FLIT_W outgoing flits, registered
//   out_req   out  5 outgoing flit valid
//   in_ack    in   5 downstream ready
module noc_router_xy #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int CW     = 4,
    parameter int X_ID   = 0,
    parameter int Y_ID   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] in_flit,
    input  logic [4:0]          in_req,
    output logic [4:0]          out_ack,
    output logic [5*FLIT_W-1:0] out_flit,
    output logic [4:0]          out_req,
    input  logic [4:0]          in_ack
);
    localparam int NP   = 5;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0] X_C = CW'(X_ID);
    localparam logic [CW-1:0] Y_C = CW'(Y_ID);
    localparam logic [1:0] T_HEAD = 2'b10;

    // Input FIFOs
    logic [FLIT_W-1:0] mem [NP][DEPTH];
    logic [AW-1:0]     wr_ptr [NP];
    logic [AW-1:0]     rd_ptr [NP];
    logic [CNTW-1:0]   count [NP];

    // An input is ROUTED while some output is locked to it; the owning
    // output's lock records the route, so no per-input copy is kept.
    logic [NP-1:0] in_routed;
    logic [NP-1:0] out_locked;
    logic [2:0]    out_owner [NP];
    logic [2:0]    last_grant [NP];

    logic [FLIT_W-1:0] head [NP];
    logic [1:0]        htype [NP];
    logic [2:0]        hroute [NP];
    logic [NP-1:0]     fifo_ne;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;
    logic [NP-1:0]     drop;
    logic [NP-1:0]     fwd;
    logic [NP-1:0]     grant;
    logic [NP-1:0]     can_load;
    logic [2:0]        sel [NP];

    function automatic logic [2:0] xy_route(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
        if (dx > X_C)      return 3'd2;
        else if (dx < X_C) return 3'd4;
        else if (dy > Y_C) return 3'd1;
        else if (dy < Y_C) return 3'd3;
        else               return 3'd0;
    endfunction

    // FIFO head decode; out_ack comes only from the registered count
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            out_ack[p] = (count[p] != CNTW'(DEPTH));
            head[p]    = mem[p][rd_ptr[p]];
            htype[p]   = head[p][FLIT_W-1 -: 2];
            hroute[p]  = xy_route(head[p][2*CW-1:CW], head[p][CW-1:0]);
            fifo_ne[p] = (count[p] != '0);
            push[p]    = in_req[p] && out_ack[p];
            // body/tail arriving at an IDLE input has no route: discard it
            drop[p]    = fifo_ne[p] && !in_routed[p] && !htype[p][1];
        end
    end

    // Per-output source selection: owner when locked, else round-robin
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        pop   = drop;
        fwd   = '0;
        grant = '0;
        for (int o = 0; o < NP; o++) begin
            sel[o]      = '0;
            can_load[o] = !out_req[o] || in_ack[o];
            if (out_locked[o]) begin
                sel[o] = out_owner[o];
                fwd[o] = fifo_ne[out_owner[o]] && can_load[o];
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NP; k++) begin
                    idx = int'(last_grant[o]) + k;
                    if (idx >= NP) idx = idx - NP;
                    if (!found && fifo_ne[idx] && !in_routed[idx] && htype[idx][1]
                        && hroute[idx] == 3'(o)) begin
                        found  = 1'b1;
                        sel[o] = 3'(idx);
                    end
                end
                fwd[o]   = found && can_load[o];
                grant[o] = fwd[o];
            end
            if (fwd[o]) pop[sel[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_flit[p*FLIT_W +: FLIT_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p]     <= '0;
                rd_ptr[p]     <= '0;
                count[p]      <= '0;
                out_owner[p]  <= '0;
                last_grant[p] <= 3'd4;
            end
            in_routed  <= '0;
            out_locked <= '0;
            out_req    <= '0;
            out_flit   <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                count[p] <= count[p] + CNTW'(push[p]) - CNTW'(pop[p]);
            end
            for (int o = 0; o < NP; o++) begin
                if (fwd[o]) begin
                    out_flit[o*FLIT_W +: FLIT_W] <= head[sel[o]];
                    out_req[o]                   <= 1'b1;
                end else if (in_ack[o]) begin
                    out_req[o] <= 1'b0;
                end
                if (grant[o]) begin
                    last_grant[o] <= sel[o];
                    // a single flit passes through without holding the output
                    if (htype[sel[o]] == T_HEAD) begin
                        out_locked[o]     <= 1'b1;
                        out_owner[o]      <= sel[o];
                        in_routed[sel[o]] <= 1'b1;
                    end
                end
                // tail or single (type bit 0 set) ends the packet
                if (out_locked[o] && fwd[o] && htype[out_owner[o]][0]) begin
                    out_locked[o]          <= 1'b0;
                    in_routed[out_owner[o]] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_router_xy.sv
// tb/tb_noc_router_xy.sv - directed self-checking bench for noc_router_xy
module tb_noc_router_xy;
    localparam int FW = 34;
    localparam logic [1:0] TH = 2'b10, TB = 2'b00, TT = 2'b01, TS = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [5*FW-1:0] in_flit;
    logic [4:0]    in_req;
    logic [4:0]    out_ack;
    logic [5*FW-1:0] out_flit;
    logic [4:0]    out_req;
    logic [4:0]    in_ack;

    always #5 clk = ~clk;

    noc_router_xy #(.FLIT_W(FW), .DEPTH(4), .CW(4), .X_ID(1), .Y_ID(1)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_req(in_req), .out_ack(out_ack),
        .out_flit(out_flit), .out_req(out_req), .in_ack(in_ack)
    );

    logic [FW-1:0] tx_mem [5][32];
    int            tx_wr [5] = '{default: 0};
    int            tx_rd [5] = '{default: 0};
    logic [4:0]    xfer_in = '0;
    logic [FW-1:0] rx_mem [5][64];
    int            rx_cnt [5] = '{default: 0};
    int            nchk = 0, npass = 0, nfail = 0;

    // Transfers are decided at the negedge: req/ack are stable until the next posedge.
    always @(negedge clk) begin
        xfer_in = rst ? 5'b0 : (in_req & out_ack);
        for (int o = 0; o < 5; o++) begin
            if (!rst && out_req[o] && in_ack[o] && rx_cnt[o] < 64) begin
                rx_mem[o][rx_cnt[o]] = out_flit[o*FW +: FW];
                rx_cnt[o]++;
            end
        end
    end

    // Per-port senders: present queued flits, advance after each accepted transfer
    initial begin
        in_req  = '0;
        in_flit = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 5; p++) begin
                if (xfer_in[p]) tx_rd[p]++;
                if (tx_rd[p] < tx_wr[p]) begin
                    in_flit[p*FW +: FW] = tx_mem[p][tx_rd[p]];
                    in_req[p] = 1'b1;
                end else begin
                    in_req[p] = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [15:0] tag,
                                         input logic [3:0] dx, input logic [3:0] dy);
        return {t, 8'h00, tag, dx, dy};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [FW-1:0] f);
        tx_mem[p][tx_wr[p]] = f;
        tx_wr[p]++;
    endtask

    task automatic wait_rx(input int o, input int n);
        for (int i = 0; i < 120 && rx_cnt[o] < n; i++) @(posedge clk);
    endtask

    logic [FW-1:0] f, fe [6];
    int b0, b1, b2, b3, b4;

    initial begin
        rst    = 1'b1;
        in_ack = 5'h1f;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_req", 64'(out_req), 64'(0));
        check("rst_out_flit", 64'(|out_flit), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #3;
        check("rst_out_ack", 64'(out_ack), 64'h1f);

        // local delivery and minimum latency
        f  = mk(TS, 16'h0001, 4'd1, 4'd1);
        b0 = rx_cnt[0];
        @(posedge clk);
        #2;
        push(0, f);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("lat_e1_req", 64'(out_req), 64'(0));
        @(posedge clk);
        #3;
        check("lat_e2_req", 64'(out_req), 64'h01);
        check("lat_e2_flit", 64'(out_flit[0 +: FW]), 64'(f));
        repeat (3) @(posedge clk);
        check("local_cnt", 64'(rx_cnt[0] - b0), 64'(1));

        // XY routing, X resolved before Y
        b0 = rx_cnt[0]; b1 = rx_cnt[1]; b2 = rx_cnt[2]; b3 = rx_cnt[3]; b4 = rx_cnt[4];
        fe[0] = mk(TS, 16'h0010, 4'd3, 4'd0);
        fe[1] = mk(TS, 16'h0011, 4'd0, 4'd2);
        fe[2] = mk(TS, 16'h0012, 4'd1, 4'd3);
        fe[3] = mk(TS, 16'h0013, 4'd1, 4'd0);
        fe[4] = mk(TS, 16'h0014, 4'd2, 4'd2);
        fe[5] = mk(TS, 16'h0015, 4'd0, 4'd0);
        for (int i = 0; i < 6; i++) push(0, fe[i]);
        wait_rx(4, b4 + 2);
        repeat (5) @(posedge clk);
        check("xy_east_cnt", 64'(rx_cnt[2] - b2), 64'(2));
        check("xy_west_cnt", 64'(rx_cnt[4] - b4), 64'(2));
        check("xy_north_cnt", 64'(rx_cnt[1] - b1), 64'(1));
        check("xy_south_cnt", 64'(rx_cnt[3] - b3), 64'(1));
        check("xy_local_cnt", 64'(rx_cnt[0] - b0), 64'(0));
        check("xy_east0", 64'(rx_mem[2][b2]), 64'(fe[0]));
        check("xy_east1", 64'(rx_mem[2][b2+1]), 64'(fe[4]));
        check("xy_west0", 64'(rx_mem[4][b4]), 64'(fe[1]));
        check("xy_west1", 64'(rx_mem[4][b4+1]), 64'(fe[5]));
        check("xy_north", 64'(rx_mem[1][b1]), 64'(fe[2]));
        check("xy_south", 64'(rx_mem[3][b3]), 64'(fe[3]));

        // round robin after reset: sources 1,2,3,1,2,3,...
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        b0 = rx_cnt[0];
        for (int s = 0; s < 4; s++)
            for (int p = 1; p < 4; p++) push(p, mk(TS, 16'(p*16 + s), 4'd1, 4'd1));
        wait_rx(0, b0 + 12);
        for (int k = 0; k < 12; k++)
            check($sformatf("rr_%0d", k), 64'(rx_mem[0][b0+k]),
                  64'(mk(TS, 16'((1 + k % 3)*16 + k / 3), 4'd1, 4'd1)));

        // wormhole: input 1's packet stays contiguous ahead of input 3's single
        b2 = rx_cnt[2];
        fe[0] = mk(TH, 16'h0100, 4'd3, 4'd1);
        fe[1] = mk(TB, 16'h0101, 4'd3, 4'd1);
        fe[2] = mk(TB, 16'h0102, 4'd3, 4'd1);
        fe[3] = mk(TB, 16'h0103, 4'd3, 4'd1);
        fe[4] = mk(TT, 16'h0104, 4'd3, 4'd1);
        fe[5] = mk(TS, 16'h0300, 4'd3, 4'd1);
        for (int i = 0; i < 5; i++) push(1, fe[i]);
        push(3, fe[5]);
        wait_rx(2, b2 + 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("wh_%0d", i), 64'(rx_mem[2][b2+i]), 64'(fe[i]));

        // backpressure on east with a 6-flit packet from local
        @(posedge clk);
        #2;
        in_ack[2] = 1'b0;
        b2 = rx_cnt[2];
        fe[0] = mk(TH, 16'h0200, 4'd3, 4'd1);
        for (int i = 1; i < 5; i++) fe[i] = mk(TB, 16'(16'h0200 + i), 4'd3, 4'd1);
        fe[5] = mk(TT, 16'h0205, 4'd3, 4'd1);
        for (int i = 0; i < 6; i++) push(0, fe[i]);
        repeat (15) @(posedge clk);
        #3;
        check("bp_out_ack0", 64'(out_ack[0]), 64'(0));
        check("bp_out_req2", 64'(out_req[2]), 64'(1));
        check("bp_hold_flit", 64'(out_flit[2*FW +: FW]), 64'(fe[0]));
        check("bp_none_out", 64'(rx_cnt[2] - b2), 64'(0));
        in_ack[2] = 1'b1;
        wait_rx(2, b2 + 6);
        repeat (5) @(posedge clk);
        check("bp_cnt", 64'(rx_cnt[2] - b2), 64'(6));
        for (int i = 0; i < 6; i++)
            check($sformatf("bp_%0d", i), 64'(rx_mem[2][b2+i]), 64'(fe[i]));

        // reset mid-packet: east locked to input 0 with the head held in the output
        @(posedge clk);
        #2;
        in_ack[2] = 1'b0;
        push(0, mk(TH, 16'h0400, 4'd3, 4'd1));
        push(0, mk(TB, 16'h0401, 4'd3, 4'd1));
        repeat (6) @(posedge clk);
        #3;
        check("mid_out_req2", 64'(out_req[2]), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_req", 64'(out_req), 64'(0));
        check("mid_rst_flit", 64'(|out_flit), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        in_ack = 5'h1f;
        #1;
        check("mid_out_ack", 64'(out_ack), 64'h1f);
        b2 = rx_cnt[2];
        f  = mk(TS, 16'h0500, 4'd3, 4'd1);
        push(1, f);
        wait_rx(2, b2 + 1);
        repeat (3) @(posedge clk);
        check("mid_new_cnt", 64'(rx_cnt[2] - b2), 64'(1));
        check("mid_new_flit", 64'(rx_mem[2][b2]), 64'(f));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
